ppu_sched: RTL and testbench
============================

PPU_SCHED -- requirements
Module: ppu_sched

Interface
REQ-001 The block SHALL have parameter PSUM_W, default 384, meaning partial-sum row width (16 lanes x 24 bit).
REQ-002 The block SHALL have parameter OUT_W, default 128, meaning quantized row width (16 lanes x 8 bit).
REQ-003 The block SHALL have parameter ADDR_W, default 8, meaning buffer address width.
REQ-004 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for ppu_done.
REQ-005 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  configuration write strobe.
- cfg_scale  in  8  scale value written on cfg_we.
- cfg_bias  in  8  bias value written on cfg_we.
- start  in  1  single-cycle job start pulse.
- num_rows  in  ADDR_W  row count, sampled on start.
- busy  out  1  high while a job is active.
- acc_rd_en  out  1  accumulator buffer read strobe.
- acc_rd_addr  out  ADDR_W  accumulator read address.
- acc_rd_data  in  PSUM_W  read data, valid exactly 1 cycle after acc_rd_en.
- ppu_valid  out  1  PPU request level.
- ppu_partial_sum  out  PSUM_W  row sent to the PPU.
- ppu_scale  out  8  PPU scale.
- ppu_bias  out  8  PPU bias.
- ppu_done  in  1  PPU result-ready pulse.
- ppu_output_data  in  OUT_W  PPU result, valid while ppu_done is high.
- out_wr_en  out  1  output buffer write strobe.
- out_wr_addr  out  ADDR_W  output write address.
- out_wr_data  out  OUT_W  output write data.
- job_done  out  1  one-cycle pulse at job end.
- err_timeout  out  1  sticky timeout flag.

Function
REQ-006 The FSM SHALL have the states IDLE, READ, WAIT_RD, ISSUE, WAIT_PPU, WRITE and FINISH.
REQ-007 In IDLE, a start pulse SHALL latch num_rows, cfg_scale/cfg_bias shadow registers into job registers, clear the row index to 0 and enter READ; busy SHALL be high in every state except IDLE.
REQ-008 When num_rows is 0, start SHALL go IDLE->FINISH, performing no read, no PPU request and no write.
REQ-009 READ SHALL assert acc_rd_en for exactly 1 cycle with acc_rd_addr equal to the row index, then enter WAIT_RD.
REQ-010 WAIT_RD SHALL capture acc_rd_data into ppu_partial_sum and enter ISSUE.
REQ-011 In ISSUE and WAIT_PPU, ppu_valid SHALL be held high and ppu_partial_sum, ppu_scale and ppu_bias SHALL be held stable; ppu_valid SHALL deassert in the cycle after ppu_done is sampled high.
REQ-012 ppu_done sampled high in ISSUE or WAIT_PPU SHALL capture ppu_output_data and enter WRITE.
REQ-013 WRITE SHALL pulse out_wr_en for 1 cycle with out_wr_addr equal to the row index; it SHALL then increment the row index and go to READ if rows remain, else to FINISH.
REQ-014 FINISH SHALL pulse job_done for 1 cycle and return to IDLE.
REQ-015 Per-row latency SHALL be 5 cycles plus the PPU latency.
REQ-016 cfg_we SHALL update the shadow scale/bias in any state; a running job SHALL use only the values latched at its start.
REQ-017 start while busy SHALL be ignored without any side effect.
REQ-018 ppu_done while not in ISSUE/WAIT_PPU SHALL be ignored.
REQ-019 The row index SHALL be ADDR_W bits wide, and num_rows = 2^ADDR_W-1 SHALL complete without wrap.

Reset
REQ-020 Asserting rst_n low SHALL, asynchronously at any time including mid-job, force state IDLE and all outputs, shadow registers and job registers to 0.
REQ-021 A job in flight when reset is asserted SHALL be abandoned, and no write or job_done SHALL occur for it.

Configuration
REQ-022 With PPU_TIMEOUT_EN defined, a counter SHALL count cycles spent in ISSUE/WAIT_PPU; reaching TIMEOUT without ppu_done SHALL set err_timeout, drop ppu_valid and return to IDLE without a write or job_done.
REQ-023 err_timeout SHALL clear only on reset or on the next accepted start.
REQ-024 Without PPU_TIMEOUT_EN, no counter SHALL be built, err_timeout SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Structure
REQ-025 The package ppu_pkg SHALL hold the FSM state enum, the default lane count (16), the lane widths (24/8) and the default TIMEOUT.
REQ-026 The timeout counter SHALL be the single sub-module ppu_watchdog, instantiated only under PPU_TIMEOUT_EN.

Verification
REQ-027 The bench SHALL drive cfg 16/1, start with num_rows=3 and a PPU model of 4-cycle latency; it SHALL require reads at addresses 0,1,2, writes at 0,1,2 in order, ppu_scale=16, ppu_bias=1 and job_done once at cycle 3x9+2.
REQ-028 The bench SHALL drive start with num_rows=0 and SHALL require job_done 2 cycles later, with no acc_rd_en, ppu_valid or out_wr_en.
REQ-029 The bench SHALL drive cfg_we=5/2 mid-job and start twice while busy; it SHALL require the running job to keep 16/1, the extra starts to be ignored, and the next job to use 5/2.
REQ-030 The bench SHALL drive rst_n low during WAIT_PPU of row 1 and SHALL require immediate zero outputs, no write to address 1 and no job_done.
REQ-031 With PPU_TIMEOUT_EN and a PPU that never asserts ppu_done, the bench SHALL require err_timeout set 64 cycles after ISSUE entry, return to IDLE, and the flag cleared by the next start.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU row scheduler: FSM states, lane geometry and
// the default PPU timeout.
package ppu_pkg;

    localparam int LANES       = 16;
    localparam int PSUM_LANE_W = 24;
    localparam int OUT_LANE_W  = 8;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RD,
        ISSUE,
        WAIT_PPU,
        WRITE,
        FINISH
    } ppu_state_e;

endpackage

// File: rtl/ppu_watchdog.sv
// PPU response watchdog: down-counter reloaded while idle, flags expiry on the
// TIMEOUT-th consecutive active cycle.
module ppu_watchdog
    import ppu_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (!active) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = active && (cnt == '0);

endmodule

// File: rtl/ppu_sched.sv
// Row scheduler: streams rows from the accumulator buffer through the PPU into
// the output buffer. Define PPU_TIMEOUT_EN to build the ppu_done watchdog.
//
// state    | meaning
// IDLE     | waiting for start
// READ     | acc buffer read strobe for current row
// WAIT_RD  | capture read data
// ISSUE    | first cycle of PPU request
// WAIT_PPU | holding request until ppu_done
// WRITE    | output buffer write of current row
// FINISH   | end of job, job_done follows next cycle
module ppu_sched
    import ppu_pkg::*;
#(
    parameter int PSUM_W  = LANES * PSUM_LANE_W,
    parameter int OUT_W   = LANES * OUT_LANE_W,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_scale,
    input  logic [7:0]        cfg_bias,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_rows,
    output logic              busy,
    output logic              acc_rd_en,
    output logic [ADDR_W-1:0] acc_rd_addr,
    input  logic [PSUM_W-1:0] acc_rd_data,
    output logic              ppu_valid,
    output logic [PSUM_W-1:0] ppu_partial_sum,
    output logic [7:0]        ppu_scale,
    output logic [7:0]        ppu_bias,
    input  logic              ppu_done,
    input  logic [OUT_W-1:0]  ppu_output_data,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [OUT_W-1:0]  out_wr_data,
    output logic              job_done,
    output logic              err_timeout
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("ppu_sched: TIMEOUT must be at least 1");
    end

    ppu_state_e        state, state_nxt;
    logic [7:0]        shadow_scale, shadow_bias;
    logic [7:0]        job_scale, job_bias;
    logic [ADDR_W-1:0] job_rows, row_idx;
    logic [PSUM_W-1:0] psum_q;
    logic [OUT_W-1:0]  out_q;
    logic              job_done_q;
    logic              ppu_active, last_row, accept, timeout_hit;

    assign ppu_active = (state == ISSUE) || (state == WAIT_PPU);
    assign last_row   = (row_idx == job_rows - ADDR_W'(1));
    assign accept     = (state == IDLE) && start;

`ifdef PPU_TIMEOUT_EN
    logic wd_expired;
    logic err_q;

    ppu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (ppu_active),
        .expired (wd_expired)
    );

    // A late ppu_done on the expiry cycle still completes the row.
    assign timeout_hit = wd_expired && !ppu_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_rows == '0) ? FINISH : READ;
                end
            end
            READ:    state_nxt = WAIT_RD;
            WAIT_RD: state_nxt = ISSUE;
            ISSUE, WAIT_PPU: begin
                if (ppu_done) begin
                    state_nxt = WRITE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_PPU;
                end
            end
            WRITE:   state_nxt = last_row ? FINISH : READ;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        acc_rd_en = 1'b0;
        ppu_valid = 1'b0;
        out_wr_en = 1'b0;
        case (state)
            READ:            acc_rd_en = 1'b1;
            ISSUE, WAIT_PPU: ppu_valid = 1'b1;
            WRITE:           out_wr_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_scale <= '0;
            shadow_bias  <= '0;
            job_scale    <= '0;
            job_bias     <= '0;
            job_rows     <= '0;
            row_idx      <= '0;
            psum_q       <= '0;
            out_q        <= '0;
            job_done_q   <= 1'b0;
        end else begin
            if (cfg_we) begin
                shadow_scale <= cfg_scale;
                shadow_bias  <= cfg_bias;
            end
            if (accept) begin
                job_rows  <= num_rows;
                job_scale <= shadow_scale;
                job_bias  <= shadow_bias;
                row_idx   <= '0;
            end
            if (state == WAIT_RD) begin
                psum_q <= acc_rd_data;
            end
            if (ppu_active && ppu_done) begin
                out_q <= ppu_output_data;
            end
            if ((state == WRITE) && !last_row) begin
                row_idx <= row_idx + ADDR_W'(1);
            end
            job_done_q <= (state == FINISH);
        end
    end

    assign acc_rd_addr     = row_idx;
    assign out_wr_addr     = row_idx;
    assign ppu_partial_sum = psum_q;
    assign ppu_scale       = job_scale;
    assign ppu_bias        = job_bias;
    assign out_wr_data     = out_q;
    assign job_done        = job_done_q;

endmodule

// File: tb/tb_ppu_sched.sv
// Self-checking bench for ppu_sched with behavioural accumulator-buffer and PPU
// models; expected traces come from the job description (rows, latency, cfg).
module tb_ppu_sched;

    localparam int PSUM_W  = 384;
    localparam int OUT_W   = 128;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [7:0]        cfg_scale = '0, cfg_bias = '0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] num_rows = '0;
    logic              busy, acc_rd_en, ppu_valid, out_wr_en, job_done, err_timeout;
    logic [ADDR_W-1:0] acc_rd_addr, out_wr_addr;
    logic [PSUM_W-1:0] acc_rd_data, ppu_partial_sum;
    logic [7:0]        ppu_scale, ppu_bias;
    logic              ppu_done;
    logic [OUT_W-1:0]  ppu_output_data, out_wr_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ppu_sched #(.PSUM_W(PSUM_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_scale(cfg_scale), .cfg_bias(cfg_bias),
        .start(start), .num_rows(num_rows), .busy(busy),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
        .ppu_valid(ppu_valid), .ppu_partial_sum(ppu_partial_sum), .ppu_scale(ppu_scale),
        .ppu_bias(ppu_bias), .ppu_done(ppu_done), .ppu_output_data(ppu_output_data),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .job_done(job_done), .err_timeout(err_timeout)
    );

    logic [PSUM_W-1:0] mem [256];
    int  lat = 4;
    bit  ppu_on = 1'b1;

    // Reference PPU transform: per lane, low byte of the psum xor scale, plus bias.
    function automatic logic [OUT_W-1:0] ppu_func(logic [PSUM_W-1:0] p, logic [7:0] s, logic [7:0] b);
        logic [OUT_W-1:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = (p[i*24 +: 8] ^ s) + b;
        return r;
    endfunction

    // Accumulator buffer: data valid exactly one cycle after the read strobe.
    initial begin
        logic [ADDR_W-1:0] a;
        acc_rd_data = '0;
        forever begin
            @(negedge clk);
            if (acc_rd_en) begin
                a = acc_rd_addr;
                @(posedge clk); #1 acc_rd_data = mem[a];
                @(posedge clk); #1 for (int j = 0; j < 12; j++) acc_rd_data[j*32 +: 32] = $urandom;
            end
        end
    end

    // PPU: result lat cycles after the request is registered on its input.
    initial begin
        logic [OUT_W-1:0] r;
        ppu_done = 1'b0;
        ppu_output_data = '0;
        forever begin
            @(negedge clk);
            if (ppu_on && ppu_valid && rst_n) begin
                r = ppu_func(ppu_partial_sum, ppu_scale, ppu_bias);
                repeat (lat + 1) @(posedge clk);
                #1 ppu_done = 1'b1; ppu_output_data = r;
                @(posedge clk);
                #1 ppu_done = 1'b0;
                for (int j = 0; j < 4; j++) ppu_output_data[j*32 +: 32] = $urandom;
            end
        end
    end

    int rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_cyc_q[$], jd_q[$];
    logic [OUT_W-1:0] wr_data_q[$];
    logic [7:0] exp_sc = '0, exp_bi = '0;
    int sc_bad = 0, stab_bad = 0;

    initial begin
        logic [PSUM_W+15:0] prev;
        logic prev_vld;
        prev_vld = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (acc_rd_en) begin rd_addr_q.push_back(int'(acc_rd_addr)); rd_cyc_q.push_back(cyc); end
            if (out_wr_en) begin
                wr_addr_q.push_back(int'(out_wr_addr)); wr_cyc_q.push_back(cyc); wr_data_q.push_back(out_wr_data);
            end
            if (job_done) jd_q.push_back(cyc);
            if (ppu_valid && (ppu_scale !== exp_sc || ppu_bias !== exp_bi)) sc_bad++;
            if (ppu_valid && prev_vld && prev !== {ppu_partial_sum, ppu_scale, ppu_bias}) stab_bad++;
            prev_vld = ppu_valid;
            prev = {ppu_partial_sum, ppu_scale, ppu_bias};
        end
    end

    task automatic clear_log();
        rd_addr_q.delete(); rd_cyc_q.delete(); wr_addr_q.delete(); wr_cyc_q.delete();
        wr_data_q.delete(); jd_q.delete(); sc_bad = 0; stab_bad = 0;
    endtask

    task automatic write_cfg(input logic [7:0] s, input logic [7:0] b);
        @(posedge clk); #1 cfg_we = 1'b1; cfg_scale = s; cfg_bias = b;
        @(posedge clk); #1 cfg_we = 1'b0;
    endtask

    task automatic start_job(input int n);
        @(posedge clk); #1 num_rows = ADDR_W'(n); start = 1'b1; t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_job(input int budget);
        for (int i = 0; i < budget && jd_q.size() == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({busy, acc_rd_en, ppu_valid, out_wr_en, job_done, err_timeout} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000",
                            {busy, acc_rd_en, ppu_valid, out_wr_en, job_done, err_timeout});
        end
        total++;
        if ({acc_rd_addr, out_wr_addr, ppu_scale, ppu_bias, ppu_partial_sum, out_wr_data} !== '0) begin
            bad++; $display("FAIL reset_data got=nonzero want=0");
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int e;
        write_cfg(8'd16, 8'd1);
        exp_sc = 8'd16; exp_bi = 8'd1; lat = 4; ppu_on = 1'b1;
        clear_log();
        start_job(3);
        wait_job(100);
        total++;
        if (jd_q.size() != 1 || jd_q[0] != t0 + 29) begin
            bad++; $display("FAIL basic_job_done got=%0d@%0d want=1@%0d", jd_q.size(),
                            (jd_q.size() > 0) ? jd_q[0] - t0 : -1, 29);
        end
        total++;
        if (rd_addr_q.size() != 3 || wr_addr_q.size() != 3) begin
            bad++; $display("FAIL basic_counts got=rd%0d/wr%0d want=rd3/wr3", rd_addr_q.size(), wr_addr_q.size());
        end else begin
            e = 0;
            for (int r = 0; r < 3; r++) begin
                if (rd_addr_q[r] != r || rd_cyc_q[r] != t0 + 1 + 9*r) e++;
                if (wr_addr_q[r] != r || wr_cyc_q[r] != t0 + 9 + 9*r) e++;
                if (wr_data_q[r] !== ppu_func(mem[r], 8'd16, 8'd1)) e++;
            end
            total++;
            if (e != 0) begin bad++; $display("FAIL basic_rows got=%0d_errors want=0", e); end
        end
        total++;
        if (sc_bad != 0 || stab_bad != 0) begin
            bad++; $display("FAIL basic_ppu_hold got=sc%0d/stab%0d want=0/0", sc_bad, stab_bad);
        end
        total++;
        if (err_timeout !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_idle got=err%b/busy%b want=0/0", err_timeout, busy);
        end
    endtask

    task automatic test_zero_rows();
        clear_log();
        start_job(0);
        wait_job(20);
        total++;
        if (jd_q.size() != 1 || jd_q[0] != t0 + 2) begin
            bad++; $display("FAIL zero_job_done got=%0d@%0d want=1@2", jd_q.size(),
                            (jd_q.size() > 0) ? jd_q[0] - t0 : -1);
        end
        total++;
        if (rd_addr_q.size() != 0 || wr_addr_q.size() != 0 || sc_bad != 0) begin
            bad++; $display("FAIL zero_activity got=rd%0d/wr%0d want=0/0", rd_addr_q.size(), wr_addr_q.size());
        end
    endtask

    task automatic test_cfg_busy();
        int e;
        exp_sc = 8'd16; exp_bi = 8'd1; lat = 4;
        clear_log();
        start_job(3);
        repeat (6) @(posedge clk);
        #1 cfg_we = 1'b1; cfg_scale = 8'd5; cfg_bias = 8'd2;
        @(posedge clk); #1 cfg_we = 1'b0; num_rows = 8'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_job(100);
        total++;
        if (jd_q.size() != 1 || jd_q[0] != t0 + 29 || wr_addr_q.size() != 3) begin
            bad++; $display("FAIL cfg_busy_job1 got=jd%0d/wr%0d want=jd1/wr3", jd_q.size(), wr_addr_q.size());
        end
        total++;
        if (sc_bad != 0) begin bad++; $display("FAIL cfg_busy_keep got=%0d_bad_cycles want=0", sc_bad); end
        exp_sc = 8'd5; exp_bi = 8'd2;
        clear_log();
        start_job(2);
        wait_job(100);
        e = 0;
        if (wr_addr_q.size() != 2) e++;
        else for (int r = 0; r < 2; r++) if (wr_data_q[r] !== ppu_func(mem[r], 8'd5, 8'd2)) e++;
        total++;
        if (e != 0 || sc_bad != 0 || jd_q.size() != 1) begin
            bad++; $display("FAIL cfg_busy_job2 got=%0d_errors/sc%0d want=0/0", e, sc_bad);
        end
    endtask

    task automatic test_random();
        int n, e, per;
        logic [7:0] s, b;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 6); lat = $urandom_range(0, 5);
            s = 8'($urandom); b = 8'($urandom);
            write_cfg(s, b);
            exp_sc = s; exp_bi = b; per = 5 + lat;
            clear_log();
            start_job(n);
            wait_job(n * per + 20);
            e = 0;
            if (rd_addr_q.size() != n || wr_addr_q.size() != n) e++;
            else for (int r = 0; r < n; r++) begin
                if (rd_addr_q[r] != r || rd_cyc_q[r] != t0 + 1 + r*per) e++;
                if (wr_addr_q[r] != r || wr_cyc_q[r] != t0 + 1 + r*per + 4 + lat) e++;
                if (wr_data_q[r] !== ppu_func(mem[r], s, b)) e++;
            end
            total++;
            if (e != 0 || sc_bad != 0 || stab_bad != 0) begin
                bad++; $display("FAIL random_rows it=%0d n=%0d lat=%0d got=%0d_errors want=0", it, n, lat, e);
            end
            total++;
            if (jd_q.size() != 1 || jd_q[0] != t0 + n*per + 2) begin
                bad++; $display("FAIL random_job_done it=%0d got=%0d@%0d want=1@%0d", it, jd_q.size(),
                                (jd_q.size() > 0) ? jd_q[0] - t0 : -1, n*per + 2);
            end
        end
    endtask

    task automatic test_max_rows();
        int e;
        lat = 0;
        clear_log();
        start_job(255);
        wait_job(1400);
        e = 0;
        if (wr_addr_q.size() != 255) e++;
        else for (int r = 0; r < 255; r++)
            if (wr_addr_q[r] != r || wr_data_q[r] !== ppu_func(mem[r], exp_sc, exp_bi)) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL max_rows_writes got=%0d_writes/%0d_errors want=255/0", wr_addr_q.size(), e); end
        total++;
        if (jd_q.size() != 1 || jd_q[0] != t0 + 255*5 + 2) begin
            bad++; $display("FAIL max_rows_job_done got=%0d@%0d want=1@%0d", jd_q.size(),
                            (jd_q.size() > 0) ? jd_q[0] - t0 : -1, 255*5 + 2);
        end
    endtask

    task automatic test_reset_mid_job();
        int w1;
        write_cfg(8'd16, 8'd1);
        exp_sc = 8'd16; exp_bi = 8'd1; lat = 4;
        clear_log();
        start_job(3);
        while (cyc < t0 + 14) @(negedge clk);
        total++;
        if (ppu_valid !== 1'b1 || acc_rd_addr !== 8'd1) begin
            bad++; $display("FAIL rst_mid_setup got=valid%b/row%0d want=1/1", ppu_valid, acc_rd_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, acc_rd_en, ppu_valid, out_wr_en, job_done} !== 5'b0 ||
            {acc_rd_addr, out_wr_addr, ppu_scale, ppu_bias, ppu_partial_sum, out_wr_data} !== '0) begin
            bad++; $display("FAIL rst_mid_outputs got=busy%b/valid%b/scale%0d want=0/0/0", busy, ppu_valid, ppu_scale);
        end
        clear_log();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        w1 = 0;
        foreach (wr_addr_q[i]) if (wr_addr_q[i] == 1) w1++;
        total++;
        if (w1 != 0 || jd_q.size() != 0 || wr_addr_q.size() != 0) begin
            bad++; $display("FAIL rst_mid_abandon got=wr%0d/jd%0d want=0/0", wr_addr_q.size(), jd_q.size());
        end
        exp_sc = 8'd0; exp_bi = 8'd0;
        clear_log();
        start_job(1);
        wait_job(40);
        total++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== ppu_func(mem[0], 8'd0, 8'd0) || sc_bad != 0) begin
            bad++; $display("FAIL rst_shadow_clear got=wr%0d/sc%0d want=1/0", wr_data_q.size(), sc_bad);
        end
    endtask

`ifdef PPU_TIMEOUT_EN
    task automatic test_timeout();
        int t_err;
        ppu_on = 1'b0;
        clear_log();
        start_job(2);
        t_err = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (err_timeout) begin t_err = cyc; break; end
        end
        total++;
        if (t_err != t0 + 3 + TIMEOUT) begin
            bad++; $display("FAIL timeout_cycle got=%0d want=%0d", (t_err < 0) ? -1 : t_err - t0, 3 + TIMEOUT);
        end
        total++;
        if (busy !== 1'b0 || ppu_valid !== 1'b0 || wr_addr_q.size() != 0 || jd_q.size() != 0) begin
            bad++; $display("FAIL timeout_abort got=busy%b/valid%b/wr%0d/jd%0d want=0/0/0/0",
                            busy, ppu_valid, wr_addr_q.size(), jd_q.size());
        end
        ppu_on = 1'b1;
        start_job(0);
        @(negedge clk);
        total++;
        if (err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", err_timeout); end
        repeat (3) @(posedge clk);
    endtask
`else
    task automatic test_timeout();
        total++;
        if (err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_tied got=%b want=0", err_timeout); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 12; j++) mem[i][j*32 +: 32] = $urandom;
        test_reset();
        test_basic();
        test_zero_rows();
        test_cfg_busy();
        test_random();
        test_max_rows();
        test_timeout();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=stuck want=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
